// File: rtl/map_pkg.sv
// Shared max-log MAP trellis definitions: state count, trellis length, metric width,
// successor/predecessor mapping of the 8-state trellis and the pass-control FSM encoding.
package map_pkg;

    localparam int NUM_STATES = 8;
    localparam int K          = 14;
    localparam int N          = 12;
    localparam int AW         = $clog2(K);
    localparam int GW         = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    // Successors of state i one step later in the trellis.
    function automatic int succ0(input int i);
        return 2 * (i % 4);
    endfunction

    function automatic int succ1(input int i);
        return 2 * (i % 4) + 1;
    endfunction

    // Predecessors of state j: the two states whose successor pair contains j.
    function automatic int pred0(input int j);
        return j / 2;
    endfunction

    function automatic int pred1(input int j);
        return j / 2 + 4;
    endfunction

endpackage

// File: rtl/beta_acs.sv
// Single-state beta add-compare-select: larger of two successor metrics plus the branch metric.
// Unsigned compare, a tie keeps beta_a, and the add wraps modulo 2^N.
module beta_acs
    import map_pkg::*;
#(
    parameter int N  = map_pkg::N,
    parameter int GW = map_pkg::GW
) (
    input  logic [N-1:0]  beta_a,
    input  logic [N-1:0]  beta_b,
    input  logic [GW-1:0] gamma,
    output logic [N-1:0]  beta_out
);

    logic [N-1:0] sel;
    logic [N-1:0] gamma_ext;

    always_comb begin
        gamma_ext = {{(N-GW){1'b0}}, gamma};
        sel       = (beta_b > beta_a) ? beta_b : beta_a;
        beta_out  = sel + gamma_ext;
    end

endmodule

// File: rtl/beta_backward.sv
// Backward (beta) recursion of the 8-state max-log MAP decoder: walks alpha memory from
// step K-1 down to 0, runs the beta ACS and emits lambda = alpha + beta per state.
module beta_backward
    import map_pkg::*;
#(
    parameter int N  = map_pkg::N,
    parameter int K  = map_pkg::K,
    parameter int AW = map_pkg::AW,
    parameter int GW = map_pkg::GW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [GW-1:0]           gamma,
    input  logic [NUM_STATES*N-1:0] beta_init,
    output logic                    alpha_rd_en,
    output logic [AW-1:0]           alpha_rd_addr,
    input  logic [NUM_STATES*N-1:0] alpha_rd_data,
    output logic [NUM_STATES*N-1:0] lambda,
    output logic                    lambda_valid,
    output logic [AW-1:0]           lambda_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int S = NUM_STATES;

    function automatic logic [N-1:0] add_wrap(input logic [N-1:0] a, input logic [N-1:0] b);
        return a + b;
    endfunction

    fsm_state_t       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [N-1:0]     beta_q [S];
    logic [N-1:0]     beta_d [S];
    logic [N-1:0]     bdel_q [S];
    logic [N-1:0]     bdel_d [S];
    logic [N-1:0]     acs_out [S];
    logic             rd_vld_q, rd_vld_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    logic [S*N-1:0]   lambda_q, lambda_d;
    logic             lambda_valid_q, lambda_valid_d;
    logic [AW-1:0]    lambda_idx_q, lambda_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    for (genvar i = 0; i < S; i++) begin : g_acs
        localparam int J0 = succ0(i);
        localparam int J1 = succ1(i);
        beta_acs #(.N(N), .GW(GW)) u_acs (
            .beta_a   (beta_q[J0]),
            .beta_b   (beta_q[J1]),
            .gamma    (gamma),
            .beta_out (acs_out[i])
        );
    end

    // Read port is driven straight from state/address so the read lands in the RUN cycle itself.
    always_comb begin
        rd_en   = (state_q == RUN);
        rd_addr = rd_en ? addr_q : '0;
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        beta_d         = beta_q;
        bdel_d         = bdel_q;
        rd_vld_d       = rd_en;
        rd_idx_d       = rd_addr;
        lambda_valid_d = rd_vld_q;
        lambda_idx_d   = rd_idx_q;
        lambda_d       = lambda_q;
        done_d         = (state_q == FLUSH);

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int s = 0; s < S; s++) begin
                        beta_d[s] = beta_init[s*N +: N];
                    end
                    addr_d  = AW'(K - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                bdel_d = beta_q;
                beta_d = acs_out;
                if (addr_q == '0) begin
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Alpha arrives one cycle after its read, alongside the beta that was current at the read.
        if (rd_vld_q) begin
            for (int s = 0; s < S; s++) begin
                lambda_d[s*N +: N] = add_wrap(alpha_rd_data[s*N +: N], bdel_q[s]);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            beta_q         <= '{default: '0};
            bdel_q         <= '{default: '0};
            rd_vld_q       <= 1'b0;
            rd_idx_q       <= '0;
            lambda_q       <= '0;
            lambda_valid_q <= 1'b0;
            lambda_idx_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            beta_q         <= beta_d;
            bdel_q         <= bdel_d;
            rd_vld_q       <= rd_vld_d;
            rd_idx_q       <= rd_idx_d;
            lambda_q       <= lambda_d;
            lambda_valid_q <= lambda_valid_d;
            lambda_idx_q   <= lambda_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        alpha_rd_en   = rd_en;
        alpha_rd_addr = rd_addr;
        lambda        = lambda_q;
        lambda_valid  = lambda_valid_q;
        lambda_idx    = lambda_idx_q;
        busy          = busy_q;
        done          = done_q;
    end

endmodule

// File: tb/tb_beta_backward.sv
// Directed bench for beta_backward: alpha memory model, max-log reference model and
// per-cycle checks of read port, lambda stream, busy and done.
module tb_beta_backward;

    localparam int N  = 12;
    localparam int K  = 14;
    localparam int AW = 4;
    localparam int GW = 2;
    localparam int W  = 8 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [GW-1:0] gamma;
    logic [W-1:0]  beta_init;
    logic          alpha_rd_en;
    logic [AW-1:0] alpha_rd_addr;
    logic [W-1:0]  alpha_rd_data;
    logic [W-1:0]  lambda;
    logic          lambda_valid;
    logic [AW-1:0] lambda_idx;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem [K];
    logic [GW-1:0] g_seq [K+1];
    logic [W-1:0]  b_init;
    logic [W-1:0]  exp_lam [K];
    logic [W-1:0]  cap [K];
    logic [W-1:0]  hand;
    int            checks = 0;
    int            errors = 0;
    int            n_valid;
    int            n_done;

    always #5 clk = ~clk;

    beta_backward #(.N(N), .K(K), .AW(AW), .GW(GW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .gamma         (gamma),
        .beta_init     (beta_init),
        .alpha_rd_en   (alpha_rd_en),
        .alpha_rd_addr (alpha_rd_addr),
        .alpha_rd_data (alpha_rd_data),
        .lambda        (lambda),
        .lambda_valid  (lambda_valid),
        .lambda_idx    (lambda_idx),
        .busy          (busy),
        .done          (done)
    );

    // Alpha memory with one cycle read latency.
    always @(posedge clk) begin
        if (alpha_rd_en) alpha_rd_data <= mem[alpha_rd_addr];
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] acs_model(input logic [W-1:0] b, input logic [GW-1:0] g);
        logic [W-1:0] r;
        logic [N-1:0] a0, a1, m;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            a0 = b[(2*(i%4))*N +: N];
            a1 = b[(2*(i%4)+1)*N +: N];
            m  = (a1 > a0) ? a1 : a0;
            r[i*N +: N] = m + {{(N-GW){1'b0}}, g};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] add_states(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int s = 0; s < 8; s++) r[s*N +: N] = a[s*N +: N] + b[s*N +: N];
        return r;
    endfunction

    // One backward pass: start in cycle 0, optional ignored start and optional mid-pass reset.
    task automatic run_pass(input string name, input int extra_start_at, input int rst_at);
        logic [W-1:0] b;
        int idx;
        b = b_init;
        for (int c = 1; c <= K; c++) begin
            exp_lam[K-c] = add_states(mem[K-c], b);
            b = acs_model(b, g_seq[c]);
        end
        n_valid = 0;
        n_done  = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        beta_init = b_init;
        for (int c = 1; c <= K + 4; c++) begin
            @(posedge clk); #1;
            start = (c == extra_start_at);
            rst   = (rst_at > 0) && (c == rst_at);
            gamma = (c <= K) ? g_seq[c] : '0;
            if (rst_at > 0 && c == rst_at + 1) begin
                check($sformatf("%s abort busy", name), busy, 0);
                check($sformatf("%s abort lambda_valid", name), lambda_valid, 0);
                check($sformatf("%s abort rd_en", name), alpha_rd_en, 0);
                check($sformatf("%s abort done", name), done, 0);
                @(posedge clk); #1;
                check($sformatf("%s abort no read", name), alpha_rd_en, 0);
                return;
            end
            check($sformatf("%s c%0d rd_en", name, c), alpha_rd_en, (c <= K) ? 1 : 0);
            check($sformatf("%s c%0d rd_addr", name, c), alpha_rd_addr, (c <= K) ? K - c : 0);
            check($sformatf("%s c%0d busy", name, c), busy, (c <= K + 2) ? 1 : 0);
            check($sformatf("%s c%0d done", name, c), done, (c == K + 2) ? 1 : 0);
            check($sformatf("%s c%0d lambda_valid", name, c), lambda_valid, (c >= 3 && c <= K + 2) ? 1 : 0);
            if (lambda_valid) n_valid++;
            if (done) n_done++;
            if (c >= 3 && c <= K + 2) begin
                idx = K + 2 - c;
                check($sformatf("%s c%0d lambda_idx", name, c), lambda_idx, idx);
                check($sformatf("%s idx%0d lambda", name, idx), lambda, exp_lam[idx]);
                cap[idx] = lambda;
            end
        end
        check($sformatf("%s valid count", name), n_valid, K);
        check($sformatf("%s done count", name), n_done, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        gamma     = '0;
        beta_init = '0;
        for (int k = 0; k < K; k++) mem[k] = '0;
        alpha_rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset lambda_valid", lambda_valid, 0);
        check("reset lambda", lambda, 0);
        check("reset lambda_idx", lambda_idx, 0);
        check("reset rd_en", alpha_rd_en, 0);
        check("reset rd_addr", alpha_rd_addr, 0);
        rst = 1'b0;

        // Zero alpha, zero init, constant gamma 2: lambda ramps 0,2,...,26.
        for (int c = 0; c <= K; c++) g_seq[c] = 2'd2;
        b_init = '0;
        run_pass("ramp", 0, 0);
        check("ramp idx13", cap[13], {8{12'd0}});
        check("ramp idx12", cap[12], {8{12'd2}});
        check("ramp idx0", cap[0], {8{12'd26}});

        // beta_init[s] = s exercises the successor selection.
        for (int s = 0; s < 8; s++) b_init[s*N +: N] = N'(s);
        run_pass("succ", 0, 0);
        check("succ idx12", cap[12],
              {12'd9, 12'd7, 12'd5, 12'd3, 12'd9, 12'd7, 12'd5, 12'd3});

        // All-ones init: both lambda and beta wrap.
        b_init = {8{12'hFFF}};
        mem[13] = {8{12'd1}};
        for (int s = 0; s < 8; s++) mem[12][s*N +: N] = N'($urandom_range(0, 4095));
        mem[12][0 +: N] = 12'hFFF;
        run_pass("wrap", 0, 0);
        check("wrap idx13", cap[13], '0);
        for (int s = 0; s < 8; s++) hand[s*N +: N] = mem[12][s*N +: N] + 12'd1;
        check("wrap idx12", cap[12], hand);

        // A start pulse in the middle of a pass changes nothing.
        b_init = '0;
        for (int k = 0; k < K; k++) mem[k] = '0;
        for (int c = 0; c <= K; c++) g_seq[c] = 2'd2;
        run_pass("restart", 5, 0);

        // Reset mid-pass, then a clean full pass.
        run_pass("abort", 0, 6);
        run_pass("after_abort", 0, 0);
        check("after_abort idx0", cap[0], {8{12'd26}});

        // Reset and start together: reset wins.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start busy", busy, 0);
        @(posedge clk); #1;
        check("rst_start rd_en", alpha_rd_en, 0);
        check("rst_start busy2", busy, 0);

        // Random alpha, random gamma each cycle, random init.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < K; k++)
                for (int s = 0; s < 8; s++) mem[k][s*N +: N] = N'($urandom_range(0, 4095));
            for (int s = 0; s < 8; s++) b_init[s*N +: N] = N'($urandom_range(0, 4095));
            for (int c = 0; c <= K; c++) g_seq[c] = GW'($urandom_range(0, 3));
            run_pass($sformatf("rand%0d", r), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
